// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port of alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU/consumer side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  req1_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Divides wait DIV_CYCLES extra cycles; divide-by-zero is answered locally with an error.
module alu_arbiter #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StWait, StResp} state_e;

    localparam logic [3:0] OpDiv     = 4'b0011;
    localparam logic [3:0] DivCycles = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  flg_q, flg_d;
    logic        err_q, err_d;

    logic grant0, grant1, idle, alu_busy;

    // On a tie the requester that did not win last time goes first.
    assign grant0   = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign idle     = (state_q == StIdle);
    assign alu_busy = (state_q == StExec) || (state_q == StWait);

    assign bus.req0_ready = rst_n & idle & grant0;
    assign bus.req1_ready = rst_n & idle & grant1;

    assign bus.alu_a      = alu_busy ? a_q  : 16'h0000;
    assign bus.alu_b      = alu_busy ? b_q  : 16'h0000;
    assign bus.alu_opcode = alu_busy ? op_q : 4'b0000;

    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flg_q;
    assign bus.rsp_err    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? bus.req1_a  : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b  : bus.req0_b;
                    op_d    = grant1 ? bus.req1_op : bus.req0_op;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (op_q == OpDiv && b_q == 16'h0000) begin
                    res_d   = 16'hFFFF;
                    flg_d   = 5'b00000;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (op_q == OpDiv && DivCycles != 4'd0) begin
                    cnt_d   = DivCycles;
                    state_d = StWait;
                end else begin
                    res_d   = bus.alu_result;
                    flg_d   = bus.alu_flags;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = bus.alu_result;
                    flg_d   = bus.alu_flags;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            op_q    <= 4'b0000;
            id_q    <= 1'b0;
            res_q   <= 16'h0000;
            flg_q   <= 5'b00000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU, expected responses queued at issue time,
// and a monitor that pops and compares on every response handshake.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic [4:0]  flg;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [16:0] alu_sum;

    alu_arbiter_if bus ();

    alu_arbiter #(.DIV_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0000 add, 0011 divide, anything else AND.
    always_comb begin
        alu_sum        = 17'd0;
        bus.alu_result = 16'h0000;
        bus.alu_flags  = 5'b00000;
        case (bus.alu_opcode)
            4'b0000: begin
                alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result = alu_sum[15:0];
                bus.alu_flags[0] = alu_sum[16];
                bus.alu_flags[1] = (bus.alu_a[15] == bus.alu_b[15]) &&
                                   (alu_sum[15] != bus.alu_a[15]);
            end
            4'b0011: bus.alu_result = (bus.alu_b == 16'h0) ? 16'hFFFF : bus.alu_a / bus.alu_b;
            default: bus.alu_result = bus.alu_a & bus.alu_b;
        endcase
        bus.alu_flags[4] = bus.alu_result[15];
        bus.alu_flags[3] = (bus.alu_result == 16'h0000);
        bus.alu_flags[2] = ^bus.alu_result;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input bit r, input bit v, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] op);
        if (r) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    function automatic bit rdy(input bit r);
        return r ? bus.req1_ready : bus.req0_ready;
    endfunction

    // Issue one op from a negedge, measure accept-to-valid edges, return at the rsp_valid negedge.
    task automatic do_op(input bit r, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [15:0] eres, input logic [4:0] eflg,
                         input bit eerr, input int elat);
        int guard;
        int edges;
        exp_q.push_back(exp_t'{id: r, res: eres, flg: eflg, err: eerr});
        #1 drive_req(r, 1'b1, a, b, op);
        #1;
        guard = 0;
        while (!rdy(r) && guard < 50) begin
            @(negedge clk);
            #2;
            guard++;
        end
        chk("accept_in_time", 32'(guard < 50), 32'd1);
        if (guard >= 50) begin
            drive_req(r, 1'b0, 16'h0, 16'h0, 4'h0);
            return;
        end
        @(posedge clk);
        #1 drive_req(r, 1'b0, 16'hFFFF, 16'hFFFF, 4'hF);
        edges = 1;
        @(negedge clk);
        while (!bus.rsp_valid && edges < 40) begin
            chk("alu_opcode_busy", 32'(bus.alu_opcode), 32'(op));
            chk("alu_a_busy", 32'(bus.alu_a), 32'(a));
            chk("alu_b_busy", 32'(bus.alu_b), 32'(b));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", 32'(edges), 32'(elat));
    endtask

    // Keeps valid high and collects four acceptances for requester r.
    task automatic rr_proc(input bit r);
        int guard;
        #1 drive_req(r, 1'b1, 16'h0001, {15'b0, r}, 4'b0000);
        #1;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!rdy(r) && guard < 100) begin
                @(negedge clk);
                #2;
                guard++;
            end
            chk("rr_accept_in_time", 32'(guard < 100), 32'd1);
            if (guard >= 100) break;
            @(posedge clk);
            if (k < 3) begin
                @(negedge clk);
                #2;
            end
        end
        #1 drive_req(r, 1'b0, 16'h0, 16'h0, 4'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("never_both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                    chk("rsp_result", 32'(bus.rsp_result), 32'(mon_e.res));
                    chk("rsp_flags", 32'(bus.rsp_flags), 32'(mon_e.flg));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        int guard;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 1'b1, 16'h1234, 16'h5678, 4'h0);
        drive_req(1'b1, 1'b1, 16'h1111, 16'h2222, 4'h0);

        // Reset state with both requesters valid.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FFFF + 0003 -> 0002 with carry; flags {S,Z,P,V,C} = 00101.
        do_op(1'b0, 16'hFFFF, 16'h0003, 4'b0000, 16'h0002, 5'b00101, 1'b0, 2);
        // 0010 / 0002 -> 0008 after four wait cycles.
        do_op(1'b1, 16'h0010, 16'h0002, 4'b0011, 16'h0008, 5'b00100, 1'b0, 6);

        // Both valid continuously: grants must alternate starting with requester 0.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(exp_t'{id: 1'b0, res: 16'h0001, flg: 5'b00100, err: 1'b0});
            exp_q.push_back(exp_t'{id: 1'b1, res: 16'h0002, flg: 5'b00100, err: 1'b0});
        end
        fork
            rr_proc(1'b0);
            rr_proc(1'b1);
        join
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rr_all_responses", 32'(exp_q.size()), 32'd0);

        // Divide by zero answered locally.
        do_op(1'b0, 16'h0010, 16'h0000, 4'b0011, 16'hFFFF, 5'b00000, 1'b1, 2);

        // Consumer back-pressure for five cycles.
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        do_op(1'b1, 16'h0005, 16'h0007, 4'b0000, 16'h000C, 5'b00000, 1'b0, 2);
        #1 drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 4'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_result", 32'(bus.rsp_result), 32'h000C);
            chk("stall_rsp_id", 32'(bus.rsp_id), 32'd1);
            chk("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("stall_req1_ready", 32'(bus.req1_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 chk("idle_after_consume", 32'(bus.rsp_valid), 32'd0);

        // Reset in the middle of a divide's wait phase.
        @(negedge clk);
        #1 drive_req(1'b1, 1'b1, 16'h0010, 16'h0002, 4'b0011);
        #1;
        guard = 0;
        while (!bus.req1_ready && guard < 20) begin
            @(negedge clk);
            #2;
            guard++;
        end
        chk("div_accept_in_time", 32'(guard < 20), 32'd1);
        @(posedge clk);
        #1 drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("in_wait_opcode", 32'(bus.alu_opcode), 32'b0011);
        rst_n = 1'b0;
        drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 4'h0);
        #1;
        chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("async_rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        #1;
        drive_req(1'b0, 1'b1, 16'h0001, 16'h0000, 4'h0);
        drive_req(1'b1, 1'b1, 16'h0001, 16'h0001, 4'h0);
        #1;
        chk("tie_after_rst_req0", 32'(bus.req0_ready), 32'd1);
        chk("tie_after_rst_req1", 32'(bus.req1_ready), 32'd0);
        drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DIV_CYCLES, default 4, extra cycles a divide (opcode 4'b0011) occupies the ALU before capture; legal range 0..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation of requester N accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  16 each  operands.
REQ-007 req0_op / req1_op  input  4 each  ALU opcode.
REQ-008 alu_a, alu_b  output  16 each  operands driven to the shared ALU.
REQ-009 alu_opcode  output  4  opcode driven to the shared ALU.
REQ-010 alu_result  input  16  ALU op output (combinational from alu_a/alu_b/alu_opcode).
REQ-011 alu_flags  input  5  {Sign, Zero, Parity, Overflow, Carry_fin} from the ALU.
REQ-012 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_result  output  16; rsp_flags  output  5; rsp_err  output  1  divide-by-zero indicator.

Function
REQ-015 FSM states IDLE, EXEC, WAIT, RESP; one operation in flight at a time.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-017 Grant: single valid requester wins; both valid -> requester other than last_grant wins (round-robin); last_grant updates only on acceptance.
REQ-018 On acceptance: latch a, b, op, id into operand registers; IDLE -> EXEC next edge.
REQ-019 alu_a/alu_b/alu_opcode SHALL drive the operand registers in EXEC and WAIT, and 0/0/4'b0000 otherwise.
REQ-020 EXEC, opcode != 0011 or DIV_CYCLES = 0: capture alu_result/alu_flags into rsp registers, go RESP; rsp_valid high the cycle after EXEC (accept-to-valid latency 2 edges).
REQ-021 EXEC, opcode = 0011, DIV_CYCLES > 0: load down-counter with DIV_CYCLES, go WAIT; WAIT decrements each cycle, captures and goes RESP on the cycle counter = 1 (accept-to-valid latency DIV_CYCLES+2 edges).
REQ-022 Divide with b = 0: no ALU wait; in EXEC capture rsp_result = 16'hFFFF, rsp_flags = 5'b00000, rsp_err = 1, go RESP directly; rsp_err = 0 for all other operations.
REQ-023 RESP: rsp_valid = 1; rsp_id/result/flags/err held stable until rsp_valid&rsp_ready; then -> IDLE next edge, rsp_valid low.
REQ-024 No new acceptance in the cycle a response is consumed (acceptance only in IDLE); back-to-back throughput one op per 3 cycles with rsp_ready held high.
REQ-025 Request inputs changing while not accepted SHALL have no effect; operand registers immune to input changes after acceptance.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, counter 0, last_grant = 1 (requester 0 wins first tie), operand and rsp registers 0, rsp_valid 0, reqN_ready 0 while rst_n low.
REQ-027 Reset in EXEC, WAIT or RESP discards the in-flight operation; no response emitted afterwards.

Verification
REQ-028 req0 a=FFFF b=0003 op=0000, rsp_ready=1 -> rsp_valid 2 edges after accept, result 0002, Carry_fin=1, Zero=0, id=0, err=0.
REQ-029 Both valid continuously, 4 ops each (op=0000, a=1, b=id) -> grants alternate 0,1,0,1..., responses ids alternate, none lost.
REQ-030 req1 a=0010 b=0002 op=0011, DIV_CYCLES=4 -> rsp_valid exactly 6 edges after accept, result 0008, alu_opcode=0011 held throughout EXEC/WAIT.
REQ-031 req0 a=0010 b=0000 op=0011 -> result FFFF, err=1, flags 00000, latency 2 edges.
REQ-032 rsp_ready low 5 cycles after rsp_valid -> outputs stable, reqN_ready low throughout; rsp_ready high -> IDLE next edge.
REQ-033 rst_n low during WAIT of a divide -> rsp_valid 0 immediately, no response after release, next tie grants requester 0.
